// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, with a final pass that applies the signs.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      Rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      Rd_out,
  output logic            Reg_write
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   hi_q;       // product high half / partial remainder
  logic [XLEN-1:0]   lo_q;       // multiplier bits / dividend-then-quotient
  logic [XLEN-1:0]   opnd_q;     // multiplicand / divisor magnitude
  logic              neg_q;      // negate product or quotient in FIX
  logic              rem_neg_q;  // negate remainder in FIX

  logic              accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;

  // Decode the request presented in IDLE: signedness, magnitudes, special cases.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    special_res = '1;
    is_div   = funct3[2];
    a_signed = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    b_signed = is_div ? ~funct3[0] : (funct3 == 3'b001);
    a_neg    = a_signed & operand_a[XLEN-1];
    b_neg    = b_signed & operand_b[XLEN-1];
    mag_a    = a_neg ? -operand_a : operand_a;
    mag_b    = b_neg ? -operand_b : operand_b;
    div_zero = is_div && (operand_b == '0);
    div_ovf  = is_div && !funct3[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
               && (operand_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero)
      special_res = funct3[1] ? operand_a : '1;
    else
      special_res = funct3[1] ? '0 : operand_a;  // overflow: quotient equals the dividend
    accept   = (state == IDLE) && start && !kill;
  end

  logic [XLEN-1:0]   addend, div_diff, quo_signed, rem_signed, fix_res;
  logic [XLEN:0]     mul_sum, div_trial;
  logic              div_ge;
  logic [2*XLEN-1:0] prod, prod_signed;

  // One iteration of each algorithm, plus the sign fix-up and result select.
  always_comb begin
    addend      = lo_q[0] ? opnd_q : '0;
    mul_sum     = {1'b0, hi_q} + {1'b0, addend};
    div_trial   = {hi_q, lo_q[XLEN-1]};
    div_ge      = div_trial >= {1'b0, opnd_q};
    div_diff    = div_trial[XLEN-1:0] - opnd_q;  // exact whenever div_ge holds
    prod        = {hi_q, lo_q};
    prod_signed = neg_q ? -prod : prod;
    quo_signed  = neg_q ? -lo_q : lo_q;
    rem_signed  = rem_neg_q ? -hi_q : hi_q;
    case (op_q)
      3'b000:                 fix_res = prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_signed;
      default:                fix_res = rem_signed;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: special cases bypass CALC/FIX, kill aborts any busy state but DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: begin
        if (kill)                               state_nxt = IDLE;
        else if (count == CNT_W'(XLEN - 1))     state_nxt = FIX;
      end
      FIX:     state_nxt = kill ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands at start, iterate in CALC, commit the result in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result    <= '0;
      Rd_out    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q      <= funct3;
          rd_q      <= Rd_in;
          count     <= '0;
          neg_q     <= a_neg ^ b_neg;
          rem_neg_q <= a_neg;
          hi_q      <= '0;
          lo_q      <= is_div ? mag_a : mag_b;
          opnd_q    <= is_div ? mag_b : mag_a;
          if (special) begin
            result <= special_res;
            Rd_out <= Rd_in;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (op_q[2]) begin
            hi_q <= div_ge ? div_diff : div_trial[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], div_ge};
          end else begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
        FIX: if (!kill) begin
          result <= fix_res;
          Rd_out <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign Reg_write = done && (Rd_out != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a cycle-level latency/arithmetic model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  Rd_in = '0;
  logic        busy, done, Reg_write;
  logic [31:0] result;
  logic [4:0]  Rd_out;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .Rd_in(Rd_in), .kill(kill),
    .busy(busy), .done(done), .result(result), .Rd_out(Rd_out),
    .Reg_write(Reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // Architectural result of an RV32M op, from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b000: begin p = ua * ub; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'b101: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'b110: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Model: cycles left until idle (1 = done cycle), result/rd presented.
  int          m_rem = 0;
  logic [31:0] m_result = '0, p_result = '0;
  logic [4:0]  m_rd = '0, p_rd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem    <= 0;
      m_result <= '0;
      m_rd     <= '0;
    end else if (m_rem == 0) begin
      if (start && !kill) begin
        if (is_special(funct3, operand_a, operand_b)) begin
          m_rem    <= 1;
          m_result <= ref_result(funct3, operand_a, operand_b);
          m_rd     <= Rd_in;
        end else begin
          m_rem    <= 34;
          p_result <= ref_result(funct3, operand_a, operand_b);
          p_rd     <= Rd_in;
        end
      end
    end else if (kill && m_rem > 1) begin
      m_rem <= 0;
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) begin
        m_result <= p_result;
        m_rd     <= p_rd;
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_rem != 0));
    check("done", 32'(done), 32'(m_rem == 1));
    check("reg_write", 32'(Reg_write), 32'(m_rem == 1 && m_rd != 0));
    check("result", result, m_result);
    if (m_rem == 1) check("rd_out", 32'(Rd_out), 32'(m_rd));
  end

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b; Rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle index (counted from the caller's current cycle) of done, 0 on timeout.
  task automatic wait_done(input int max_cycles, output int lat);
    lat = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                       input string name);
    int lat;
    start_op(f, a, b, rd);
    wait_done(40, lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result, exp);
    check({name, " rd_out"}, 32'(Rd_out), 32'(rd));
    check({name, " reg_write"}, 32'(Reg_write), 32'(rd != 0));
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, n_done;
    vecs[0] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 34, "mulhu"};
    vecs[1] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 34, "mulhsu"};
    vecs[2] = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd3,  32'hFFFF_FFFD, 34, "div"};
    vecs[3] = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFF, 34, "rem"};
    vecs[4] = '{3'b101, 32'd100,       32'd7,         5'd5,  32'd14,        34, "divu"};
    vecs[5] = '{3'b111, 32'd100,       32'd7,         5'd6,  32'd2,         34, "remu"};
    vecs[6] = '{3'b101, 32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF, 1,  "divu by 0"};
    vecs[7] = '{3'b110, 32'd5,         32'd0,         5'd9,  32'd5,         1,  "rem by 0"};
    vecs[8] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1,  "div ovf"};
    vecs[9] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1,  "rem ovf"};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", 32'(Rd_out), 32'd0);
    check("reset reg_write", 32'(Reg_write), 32'd0);

    do_op(3'b000, 32'hFFFF_FFFD, 32'd5, 5'd7, 32'hFFFF_FFF1, 34, "mul");

    // Asynchronous reset while CALC is at count 10.
    start_op(3'b001, 32'hFFFF_FFFD, 32'd5, 5'd7);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop reset busy", 32'(busy), 32'd0);
    check("midop reset done", 32'(done), 32'd0);
    check("midop reset result", result, 32'd0);
    check("midop reset rd_out", 32'(Rd_out), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    do_op(3'b001, 32'hFFFF_FFFD, 32'd5, 5'd7, 32'hFFFF_FFFF, 34, "mulh");

    foreach (vecs[i])
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, vecs[i].name);

    // A start while busy must not disturb the latched operation.
    start_op(3'b101, 32'd100, 32'd7, 5'd3);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; funct3 = 3'b000; operand_a = 32'd2; operand_b = 32'd3; Rd_in = 5'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40, lat);
    check("busy start latency", 32'(lat), 32'd29);
    check("busy start result", result, 32'd14);
    check("busy start rd_out", 32'(Rd_out), 32'd3);

    // Kill in cycle 12: no done, previous result retained.
    start_op(3'b000, 32'd2, 32'd3, 5'd5);
    repeat (11) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("kill no done", 32'(n_done), 32'd0);
    check("kill busy", 32'(busy), 32'd0);
    check("kill result kept", result, 32'd14);

    // Kill together with start in IDLE: the start is dropped.
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; operand_a = 32'd4; operand_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("kill+start busy", 32'(busy), 32'd0);

    // Rd_in = 0 and back-to-back starts right after DONE.
    do_op(3'b111, 32'd100, 32'd7, 5'd0, 32'd2, 34, "rd0 remu");
    do_op(3'b000, 32'd6, 32'd7, 5'd1, 32'd42, 34, "b2b mul");
    do_op(3'b101, 32'd42, 32'd6, 5'd2, 32'd7, 34, "b2b divu");

    // Kill during the DONE cycle does not suppress the done being presented.
    start_op(3'b101, 32'd5, 32'd0, 5'd4);
    kill = 1'b1;
    @(negedge clk);
    check("kill in done: done", 32'(done), 32'd1);
    check("kill in done: reg_write", 32'(Reg_write), 32'd1);
    check("kill in done: result", result, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 kill = 1'b0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: it consumes the two register read operands and the destination index.
- It returns a result, a destination index and a write strobe, which feed the register file write port.
- Multi-cycle operation. The pipeline stalls on busy until done.

Parameters:
XLEN  32  operand/result width; only 32 is supported
CNT_W  6  iteration counter width; must hold the value XLEN

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request, sampled only in IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  32  rs1 value (read_data1)
operand_b  input  32  rs2 value (read_data2)
Rd_in  input  5  destination register index
kill  input  1  pipeline flush: aborts the in-flight operation
busy  output  1  high while not in IDLE
done  output  1  one-cycle pulse when result is valid
result  output  32  operation result, held until the next done
Rd_out  output  5  destination index, registered at start
Reg_write  output  1  equals done AND (Rd_out != 0)

Behaviour:
- Reset: asynchronous, active-high, effective immediately, including mid-operation.
  - State returns to IDLE.
  - busy=0, done=0, Reg_write=0, result=0, Rd_out=0; internal counter and registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, kill=0 at edge E0:
  - Latch funct3, operands and Rd_in.
  - Go to CALC with count=0, unless a special case applies (see below).
  - busy rises after E0.
- CALC: one iteration per cycle, 32 iterations (edges E1..E32). On count==31 go to FIX.
- Multiply:
  - Shift-add on operand magnitudes into a 64-bit product.
  - Signedness: MULH signed×signed; MULHSU signed a × unsigned b; MULHU and MUL unsigned×unsigned.
  - The low word is the same for all cases.
- Divide: restoring division on magnitudes (signed ops take absolute values) → 32-bit quotient and remainder.
- FIX (E33): apply signs.
  - Product negated if exactly one signed operand is negative.
  - Quotient negated if dividend sign differs from divisor sign.
  - Remainder takes the sign of the dividend.
  - Select: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
  - Register result, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - Normal latency: done high in the 34th cycle after the start cycle.
  - A new start is accepted in the cycle after DONE.
- Special cases: decided at start; skip CALC/FIX; go straight to DONE, so done is high in the cycle after E0.
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result operand_a.
  - Signed overflow, DIV/REM with a=0x80000000, b=0xFFFFFFFF: DIV 0x80000000, REM 0.
- start while busy: ignored; latched operands are unaffected.
- kill:
  - When busy: next edge goes to IDLE; no done, no Reg_write; result keeps its previous value.
  - kill and start together in IDLE: start is ignored.
  - kill in the DONE cycle does not suppress the done already being presented.
- Rd_in=0: computed normally, done pulses, Reg_write stays 0.
- result, Rd_out: stable from DONE until the next DONE.
- No combinational path from the inputs to any output.

Test Plan:
- Reset mid-op: rst during CALC at count 10 → busy=0, done=0, result=0 immediately; a subsequent start works normally.
- MUL a=0xFFFFFFFD (−3), b=5 → done in the 34th cycle, result=0xFFFFFFF1; MULH with the same operands → 0xFFFFFFFF; Reg_write=1 with Rd_in=7 → Rd_out=7.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Specials:
  - DIVU 5/0 → 0xFFFFFFFF, done in the cycle after start.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Control:
  - start during busy → ignored, first result unchanged.
  - kill at cycle 12 → no done, prior result retained.
  - Rd_in=0 → done=1, Reg_write=0.
  - Back-to-back start right after DONE → accepted.
